// File: rtl/multi_lane_serializer_pkg.sv
// Shared constants for the multi-lane serializer: default idle word and bit-order encoding.
// Imported by the lane and top modules so every file agrees on the same defaults.
package multi_lane_serializer_pkg;

    typedef enum logic {
        ORDER_LSB = 1'b0,
        ORDER_MSB = 1'b1
    } bit_order_e;

    localparam logic [7:0] IDLE_WORD_DEFAULT = 8'hBC;

endpackage

// File: rtl/multi_lane_serializer_if.sv
// Bundle of per-lane FIFO, flow-control and serial-link signals of the multi-lane serializer.
// master = upstream/link side driving FIFO status, slave = the serializer itself.
interface multi_lane_serializer_if #(
    parameter int N_LANES   = 2,
    parameter int DATA_SIZE = 8
);

    logic [N_LANES*DATA_SIZE-1:0] in_data;
    logic [N_LANES-1:0]           fifo_empty;
    logic [N_LANES-1:0]           fifo_almost_empty;
    logic [N_LANES-1:0]           down_almost_full;
    logic [N_LANES-1:0]           lane_enable;
    logic [N_LANES-1:0]           pop;
    logic [N_LANES-1:0]           out_serial;
    logic [N_LANES-1:0]           out_valid;
    logic                         word_start;

    modport master (
        output in_data, fifo_empty, fifo_almost_empty, down_almost_full, lane_enable,
        input  pop, out_serial, out_valid, word_start
    );

    modport slave (
        input  in_data, fifo_empty, fifo_almost_empty, down_almost_full, lane_enable,
        output pop, out_serial, out_valid, word_start
    );

endinterface

// File: rtl/multi_lane_serializer_lane.sv
// One serial lane: pop gate on the shared word boundary, load/shift register and data-valid flag.
// Idle periods load the idle word so the line always carries a defined pattern.
module serializer_lane
    import multi_lane_serializer_pkg::*;
#(
    parameter int                   DATA_SIZE  = 8,
    parameter logic [DATA_SIZE-1:0] IDLE_WORD  = DATA_SIZE'(IDLE_WORD_DEFAULT),
    parameter bit                   MSB_FIRST  = ORDER_MSB,
    parameter bit                   USE_AEMPTY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 boundary_i,
    input  logic                 enable_i,
    input  logic                 empty_i,
    input  logic                 aempty_i,
    input  logic                 dn_afull_i,
    input  logic [DATA_SIZE-1:0] din_i,
    output logic                 pop_o,
    output logic                 sout_o,
    output logic                 svalid_o
);

    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 vld_q, vld_d;

    // Reset level is folded in so no read strobe can escape while the FIFOs are being cleared.
    assign pop_o = reset & boundary_i & enable_i & ~empty_i
                 & ~(USE_AEMPTY & aempty_i) & ~dn_afull_i;

    always_comb begin
        shift_d = shift_q;
        vld_d   = vld_q;
        if (boundary_i) begin
            shift_d = pop_o ? din_i : IDLE_WORD;
            vld_d   = pop_o;
        end else if (MSB_FIRST) begin
            shift_d = {shift_q[DATA_SIZE-2:0], 1'b0};
        end else begin
            shift_d = {1'b0, shift_q[DATA_SIZE-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            vld_q   <= vld_d;
        end
    end

    assign sout_o   = MSB_FIRST ? shift_q[DATA_SIZE-1] : shift_q[0];
    assign svalid_o = vld_q;

endmodule

// File: rtl/multi_lane_serializer.sv
// N-lane parallel-to-serial stage sharing one free-running bit counter across all lanes.
// The counter's last value marks the word boundary where every lane may pop and reload.
module multi_lane_serializer
    import multi_lane_serializer_pkg::*;
#(
    parameter int                   N_LANES    = 2,
    parameter int                   DATA_SIZE  = 8,
    parameter logic [DATA_SIZE-1:0] IDLE_WORD  = DATA_SIZE'(IDLE_WORD_DEFAULT),
    parameter bit                   MSB_FIRST  = ORDER_MSB,
    parameter bit                   USE_AEMPTY = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    multi_lane_serializer_if.slave  bus
);

    localparam int                CNT_W = $clog2(DATA_SIZE);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_SIZE - 1);

    logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic               boundary_q;
    logic               wordStart_q;
    logic [N_LANES-1:0] popW, soutW, svalidW;

    assign bitCnt_d = boundary_q ? '0 : bitCnt_q + CNT_W'(1);

    // Boundary and word-start are precomputed from the next count so both stay flop-driven.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bitCnt_q    <= LAST;
            boundary_q  <= 1'b1;
            wordStart_q <= 1'b0;
        end else begin
            bitCnt_q    <= bitCnt_d;
            boundary_q  <= (bitCnt_d == LAST);
            wordStart_q <= (bitCnt_d == '0);
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : gLane
        serializer_lane #(
            .DATA_SIZE (DATA_SIZE),
            .IDLE_WORD (IDLE_WORD),
            .MSB_FIRST (MSB_FIRST),
            .USE_AEMPTY(USE_AEMPTY)
        ) uLane (
            .clk       (clk),
            .reset     (reset),
            .boundary_i(boundary_q),
            .enable_i  (bus.lane_enable[i]),
            .empty_i   (bus.fifo_empty[i]),
            .aempty_i  (bus.fifo_almost_empty[i]),
            .dn_afull_i(bus.down_almost_full[i]),
            .din_i     (bus.in_data[i*DATA_SIZE +: DATA_SIZE]),
            .pop_o     (popW[i]),
            .sout_o    (soutW[i]),
            .svalid_o  (svalidW[i])
        );
    end

    assign bus.pop        = popW;
    assign bus.out_serial = soutW;
    assign bus.out_valid  = svalidW;
    assign bus.word_start = wordStart_q;

endmodule

// File: tb/tb_multi_lane_serializer.sv
// Directed bench for multi_lane_serializer: idle pattern, data words, pop gating, enable and reset.
// A second instance with the almost-empty gate disabled shares all inputs with the first.
module tb_multi_lane_serializer;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    multi_lane_serializer_if #(.N_LANES(2), .DATA_SIZE(8)) bus ();
    multi_lane_serializer_if #(.N_LANES(2), .DATA_SIZE(8)) bus2 ();

    assign bus2.in_data           = bus.in_data;
    assign bus2.fifo_empty        = bus.fifo_empty;
    assign bus2.fifo_almost_empty = bus.fifo_almost_empty;
    assign bus2.down_almost_full  = bus.down_almost_full;
    assign bus2.lane_enable       = bus.lane_enable;

    multi_lane_serializer #(
        .N_LANES(2), .DATA_SIZE(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1), .USE_AEMPTY(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    multi_lane_serializer #(
        .N_LANES(2), .DATA_SIZE(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1), .USE_AEMPTY(1'b0)
    ) dutNoAe (
        .clk  (clk),
        .reset(reset),
        .bus  (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Walks bit positions from..to of the current word on the primary instance, one negedge each.
    task automatic runBits(input logic [7:0] w0, input logic [7:0] w1, input logic [1:0] vld,
                           input int from, input int to);
        for (int b = from; b <= to; b++) begin
            @(negedge clk);
            checkOutput($sformatf("ser0_b%0d", b), 32'(bus.out_serial[0]), 32'(w0[7-b]));
            checkOutput($sformatf("ser1_b%0d", b), 32'(bus.out_serial[1]), 32'(w1[7-b]));
            checkOutput($sformatf("valid_b%0d", b), 32'(bus.out_valid), 32'(vld));
            checkOutput($sformatf("wstart_b%0d", b), 32'(bus.word_start), 32'(b == 0));
            if (b < 7) checkOutput($sformatf("popquiet_b%0d", b), 32'(bus.pop), 32'(2'b00));
        end
    endtask

    task automatic checkPop(input string tag, input logic [1:0] expected);
        #1;
        checkOutput(tag, 32'(bus.pop), 32'(expected));
    endtask

    task automatic applyStimulus(input logic [1:0] empty, input logic [1:0] aempty,
                                 input logic [1:0] afull, input logic [1:0] enable,
                                 input logic [15:0] data);
        bus.fifo_empty        = empty;
        bus.fifo_almost_empty = aempty;
        bus.down_almost_full  = afull;
        bus.lane_enable       = enable;
        bus.in_data           = data;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 16'h0000);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_serial", 32'(bus.out_serial), 32'(2'b00));
        checkOutput("rst_valid", 32'(bus.out_valid), 32'(2'b00));
        checkOutput("rst_wstart", 32'(bus.word_start), 32'(1'b0));
        checkOutput("rst_pop", 32'(bus.pop), 32'(2'b00));

        // 1: empty FIFOs, idle words on both lanes
        reset = 1'b1;
        checkPop("t1_pop_first", 2'b00);
        runBits(8'hBC, 8'hBC, 2'b00, 0, 7);
        checkPop("t1_pop_b2", 2'b00);
        runBits(8'hBC, 8'hBC, 2'b00, 0, 7);

        // 2: lane0 sends A5 then 3C back to back
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b11, 16'h00A5);
        checkPop("t2_pop_a5", 2'b01);
        runBits(8'hA5, 8'hBC, 2'b01, 0, 0);
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b11, 16'h003C);
        runBits(8'hA5, 8'hBC, 2'b01, 1, 7);
        checkPop("t2_pop_3c", 2'b01);
        runBits(8'h3C, 8'hBC, 2'b01, 0, 0);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 16'h0000);
        runBits(8'h3C, 8'hBC, 2'b01, 1, 7);
        checkPop("t2_pop_after", 2'b00);

        // 3: lane1 almost-empty blocks pop only where the gate is enabled
        applyStimulus(2'b01, 2'b10, 2'b00, 2'b11, 16'h5A00);
        checkPop("t3_pop_ae", 2'b00);
        checkOutput("t3_pop_noae", 32'(bus2.pop), 32'(2'b10));
        for (int b = 0; b < 8; b++) begin
            logic [7:0] idleWord;
            logic [7:0] dataWord;
            idleWord = 8'hBC;
            dataWord = 8'h5A;
            @(negedge clk);
            checkOutput($sformatf("t3_ser1_b%0d", b), 32'(bus.out_serial[1]), 32'(idleWord[7-b]));
            checkOutput($sformatf("t3_valid_b%0d", b), 32'(bus.out_valid), 32'(2'b00));
            checkOutput($sformatf("t3_noae_ser1_b%0d", b), 32'(bus2.out_serial[1]), 32'(dataWord[7-b]));
            checkOutput($sformatf("t3_noae_valid_b%0d", b), 32'(bus2.out_valid), 32'(2'b10));
        end
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 16'h0000);
        checkPop("t3_pop_after", 2'b00);

        // 4: downstream almost-full on lane0 holds it idle until the next boundary after release
        applyStimulus(2'b10, 2'b00, 2'b01, 2'b11, 16'h0077);
        checkPop("t4_pop_af1", 2'b00);
        runBits(8'hBC, 8'hBC, 2'b00, 0, 7);
        checkPop("t4_pop_af2", 2'b00);
        runBits(8'hBC, 8'hBC, 2'b00, 0, 3);
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b11, 16'h0077);
        runBits(8'hBC, 8'hBC, 2'b00, 4, 7);
        checkPop("t4_pop_release", 2'b01);
        runBits(8'h77, 8'hBC, 2'b01, 0, 0);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 16'h0000);
        runBits(8'h77, 8'hBC, 2'b01, 1, 7);
        checkPop("t4_pop_after", 2'b00);

        // 5: lane_enable[1] dropped mid-word, F0 completes, then idle
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b11, 16'hF000);
        checkPop("t5_pop_f0", 2'b10);
        runBits(8'hBC, 8'hF0, 2'b10, 0, 3);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b01, 16'hF000);
        runBits(8'hBC, 8'hF0, 2'b10, 4, 7);
        checkPop("t5_pop_disabled", 2'b00);
        runBits(8'hBC, 8'hBC, 2'b00, 0, 7);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 16'h0000);
        checkPop("t5_pop_after", 2'b00);

        // 6: reset mid-word discards it; first cycle after release is a boundary
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b11, 16'h0081);
        checkPop("t6_pop_81", 2'b01);
        runBits(8'h81, 8'hBC, 2'b01, 0, 0);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 16'h0000);
        runBits(8'h81, 8'hBC, 2'b01, 1, 4);
        reset = 1'b0;
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b11, 16'h0042);
        #1;
        checkOutput("t6_rst_serial", 32'(bus.out_serial), 32'(2'b00));
        checkOutput("t6_rst_valid", 32'(bus.out_valid), 32'(2'b00));
        checkOutput("t6_rst_wstart", 32'(bus.word_start), 32'(1'b0));
        checkOutput("t6_rst_pop", 32'(bus.pop), 32'(2'b00));
        @(negedge clk);
        checkOutput("t6_rst_pop_held", 32'(bus.pop), 32'(2'b00));
        reset = 1'b1;
        checkPop("t6_pop_release", 2'b01);
        runBits(8'h42, 8'hBC, 2'b01, 0, 0);
        applyStimulus(2'b11, 2'b00, 2'b00, 2'b11, 16'h0000);
        runBits(8'h42, 8'hBC, 2'b01, 1, 7);
        checkPop("t6_pop_after", 2'b00);
        runBits(8'hBC, 8'hBC, 2'b00, 0, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
